// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, controller
// states and the in-flight destination scoreboard entry.
package pipeline_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    STALL    = 2'b01,
    REDIRECT = 2'b10
  } pc_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } sb_entry_t;

  // x0 is hardwired zero, so a source of x0 never depends on an in-flight write.
  function automatic logic src_hits(logic used, logic [REG_W-1:0] rs, sb_entry_t entry);
    return used && (rs != '0) && entry.valid && (entry.rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_controller_forward_select.sv
// Per-operand forwarding mux select: youngest in-flight producer wins (EX > MEM > WB).
module forward_select
  import pipeline_pkg::*;
(
  input  logic             i_used,
  input  logic [REG_W-1:0] i_rs,
  input  sb_entry_t        i_ex,
  input  sb_entry_t        i_mem,
  input  sb_entry_t        i_wb,
  output fwd_sel_e         o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (src_hits(i_used, i_rs, i_ex)) begin
      o_sel = FWD_EX;
    end else if (src_hits(i_used, i_rs, i_mem)) begin
      o_sel = FWD_MEM;
    end else if (src_hits(i_used, i_rs, i_wb)) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_controller.sv
// Hazard and sequencing controller beside decode: scoreboard of in-flight writers,
// operand forwarding, load-use bubbles, jump flush and data-memory freeze.
module pipeline_controller
  import pipeline_pkg::*;
#(
  parameter int unsigned REGISTER_SIZE  = REG_W,
  parameter int unsigned STALL_CNT_SIZE = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      dec_valid,
  input  logic [REGISTER_SIZE-1:0]  dec_source_reg1,
  input  logic [REGISTER_SIZE-1:0]  dec_source_reg2,
  input  logic                      dec_rs1_used,
  input  logic                      dec_rs2_used,
  input  logic [REGISTER_SIZE-1:0]  dec_destination_reg,
  input  logic                      dec_rf_write_enable,
  input  logic                      dec_dm_read_enable,
  input  logic                      dec_jump_taken,
  input  logic                      mem_stall,
  output logic                      f_to_d_enable_ff,
  output logic                      f_to_d_flush,
  output logic                      d_to_e_enable_ff,
  output logic                      d_to_e_bubble,
  output logic [1:0][1:0]           pipeline_forward_sel,
  output logic [STALL_CNT_SIZE-1:0] stall_cycles
);

  pc_state_e                 r_state;
  pc_state_e                 w_state_next;
  sb_entry_t                 r_sb_ex;
  sb_entry_t                 r_sb_mem;
  sb_entry_t                 r_sb_wb;
  sb_entry_t                 w_sb_new;
  logic [STALL_CNT_SIZE-1:0] r_stall_cnt;
  logic                      w_dec_valid;
  logic                      w_load_use;
  logic                      w_jump;
  fwd_sel_e                  w_sel_rs1;
  fwd_sel_e                  w_sel_rs2;
  logic [REG_W-1:0]          w_rs1;
  logic [REG_W-1:0]          w_rs2;

  assign w_rs1 = REG_W'(dec_source_reg1);
  assign w_rs2 = REG_W'(dec_source_reg2);

  // The slot behind a taken jump was flushed to a NOP, so it never counts as valid.
  assign w_dec_valid = dec_valid && (r_state != REDIRECT);

  assign w_load_use = w_dec_valid && r_sb_ex.is_load &&
                      (src_hits(dec_rs1_used, w_rs1, r_sb_ex) ||
                       src_hits(dec_rs2_used, w_rs2, r_sb_ex));

  assign w_jump = w_dec_valid && dec_jump_taken;

  assign w_sb_new.valid   = w_dec_valid && dec_rf_write_enable && !w_load_use;
  assign w_sb_new.rd      = REG_W'(dec_destination_reg);
  assign w_sb_new.is_load = dec_dm_read_enable;

  forward_select u_fwd_rs1 (
    .i_used (dec_rs1_used),
    .i_rs   (w_rs1),
    .i_ex   (r_sb_ex),
    .i_mem  (r_sb_mem),
    .i_wb   (r_sb_wb),
    .o_sel  (w_sel_rs1)
  );

  forward_select u_fwd_rs2 (
    .i_used (dec_rs2_used),
    .i_rs   (w_rs2),
    .i_ex   (r_sb_ex),
    .i_mem  (r_sb_mem),
    .i_wb   (r_sb_wb),
    .o_sel  (w_sel_rs2)
  );

  // STALL and REDIRECT only differ from RUN through w_dec_valid, so every state shares
  // the same decision ladder: reset > mem_stall > load-use > jump flush.
  always_comb begin
    w_state_next     = r_state;
    f_to_d_enable_ff = 1'b1;
    d_to_e_enable_ff = 1'b1;
    f_to_d_flush     = 1'b0;
    d_to_e_bubble    = 1'b0;
    if (!rst) begin
      f_to_d_enable_ff = 1'b0;
      d_to_e_enable_ff = 1'b0;
      f_to_d_flush     = 1'b1;
      d_to_e_bubble    = 1'b1;
      w_state_next     = RUN;
    end else if (mem_stall) begin
      f_to_d_enable_ff = 1'b0;
      d_to_e_enable_ff = 1'b0;
    end else if (w_load_use) begin
      f_to_d_enable_ff = 1'b0;
      d_to_e_bubble    = 1'b1;
      w_state_next     = STALL;
    end else if (w_jump) begin
      f_to_d_flush     = 1'b1;
      w_state_next     = REDIRECT;
    end else begin
      w_state_next     = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= RUN;
      r_sb_ex     <= '0;
      r_sb_mem    <= '0;
      r_sb_wb     <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (!mem_stall) begin
        r_sb_wb  <= r_sb_mem;
        r_sb_mem <= r_sb_ex;
        r_sb_ex  <= w_sb_new;
      end
      if ((mem_stall || w_load_use) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_SIZE'(1);
      end
    end
  end

  assign pipeline_forward_sel[0] = rst ? w_sel_rs1 : FWD_RF;
  assign pipeline_forward_sel[1] = rst ? w_sel_rs2 : FWD_RF;
  assign stall_cycles            = rst ? r_stall_cnt : '0;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then random traffic
// compared every cycle against an instruction-level model of the hazard rules.
module tb_pipeline_controller;

  localparam int RW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           dec_valid, rs1_used, rs2_used, rf_we, dm_re, jmp, mem_stall;
  logic [RW-1:0]  rs1, rs2, rd;
  logic           f_en, f_flush, d_en, d_bub;
  logic [1:0][1:0] fwd;
  logic [CW-1:0]  cnt;

  pipeline_controller #(
    .REGISTER_SIZE  (RW),
    .STALL_CNT_SIZE (CW)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .dec_valid            (dec_valid),
    .dec_source_reg1      (rs1),
    .dec_source_reg2      (rs2),
    .dec_rs1_used         (rs1_used),
    .dec_rs2_used         (rs2_used),
    .dec_destination_reg  (rd),
    .dec_rf_write_enable  (rf_we),
    .dec_dm_read_enable   (dm_re),
    .dec_jump_taken       (jmp),
    .mem_stall            (mem_stall),
    .f_to_d_enable_ff     (f_en),
    .f_to_d_flush         (f_flush),
    .d_to_e_enable_ff     (d_en),
    .d_to_e_bubble        (d_bub),
    .pipeline_forward_sel (fwd),
    .stall_cycles         (cnt)
  );

  typedef struct {
    logic          v;
    logic [RW-1:0] rs1;
    logic          u1;
    logic [RW-1:0] rs2;
    logic          u2;
    logic [RW-1:0] rd;
    logic          we;
    logic          ld;
    logic          jmp;
  } instr_t;

  // Model: the three instructions past decode, index = distance-1 from decode.
  logic          m_v  [3];
  logic [RW-1:0] m_rd [3];
  logic          m_ld [3];
  logic          m_redir;
  int            m_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic          s_fen, s_flush, s_den, s_bub;
  logic [1:0]    s_fwd0, s_fwd1;
  logic [CW-1:0] s_cnt;
  logic          e_fen, e_den, e_flush, e_bub;

  function automatic instr_t mk(logic v, int r1, logic u1, int r2, logic u2, int d,
                                logic we, logic ld, logic j);
    instr_t x;
    x.v = v; x.rs1 = RW'(r1); x.u1 = u1; x.rs2 = RW'(r2); x.u2 = u2;
    x.rd = RW'(d); x.we = we; x.ld = ld; x.jmp = j;
    return x;
  endfunction

  task automatic set_i(input instr_t x);
    dec_valid = x.v; rs1 = x.rs1; rs1_used = x.u1; rs2 = x.rs2; rs2_used = x.u2;
    rd = x.rd; rf_we = x.we; dm_re = x.ld; jmp = x.jmp;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic m_dv();
    return dec_valid && !m_redir;
  endfunction

  // Forward select equals the distance to the nearest in-flight writer of rs.
  function automatic logic [1:0] m_fwd(logic u, logic [RW-1:0] rs);
    if (!rst || !u || rs == '0) return 2'd0;
    for (int d = 0; d < 3; d++) begin
      if (m_v[d] && m_rd[d] == rs) return 2'(d + 1);
    end
    return 2'd0;
  endfunction

  function automatic logic m_hazard();
    return m_dv() && m_v[0] && m_ld[0] && m_rd[0] != '0 &&
           ((rs1_used && rs1 == m_rd[0]) || (rs2_used && rs2 == m_rd[0]));
  endfunction

  task automatic cycle();
    logic lu, dv;
    @(negedge clk);
    lu = rst && !mem_stall && m_hazard();
    dv = m_dv();
    if (!rst)                 {e_fen, e_den, e_flush, e_bub} = 4'b0011;
    else if (mem_stall)       {e_fen, e_den, e_flush, e_bub} = 4'b0000;
    else if (lu)              {e_fen, e_den, e_flush, e_bub} = 4'b0101;
    else if (dv && jmp)       {e_fen, e_den, e_flush, e_bub} = 4'b1110;
    else                      {e_fen, e_den, e_flush, e_bub} = 4'b1100;
    s_fen = f_en; s_den = d_en; s_flush = f_flush; s_bub = d_bub;
    s_fwd0 = fwd[0]; s_fwd1 = fwd[1]; s_cnt = cnt;
    chk("f_to_d_enable_ff", 32'(s_fen), 32'(e_fen));
    chk("d_to_e_enable_ff", 32'(s_den), 32'(e_den));
    chk("f_to_d_flush", 32'(s_flush), 32'(e_flush));
    chk("d_to_e_bubble", 32'(s_bub), 32'(e_bub));
    chk("fwd_rs1", 32'(s_fwd0), 32'(m_fwd(rs1_used, rs1)));
    chk("fwd_rs2", 32'(s_fwd1), 32'(m_fwd(rs2_used, rs2)));
    chk("stall_cycles", 32'(s_cnt), rst ? 32'(m_cnt) : 32'd0);
    @(posedge clk);
    if (!rst) begin
      for (int d = 0; d < 3; d++) begin m_v[d] = 1'b0; m_rd[d] = '0; m_ld[d] = 1'b0; end
      m_redir = 1'b0;
      m_cnt   = 0;
    end else begin
      if ((mem_stall || lu) && m_cnt < (1 << CW) - 1) m_cnt++;
      if (!mem_stall) begin
        for (int d = 2; d > 0; d--) begin
          m_v[d] = m_v[d-1]; m_rd[d] = m_rd[d-1]; m_ld[d] = m_ld[d-1];
        end
        m_v[0]  = dv && !lu && rf_we;
        m_rd[0] = rd;
        m_ld[0] = dm_re;
        m_redir = dv && !lu && jmp;
      end
    end
    #1;
  endtask

  instr_t nop, cur;
  logic   hold;

  initial begin
    for (int d = 0; d < 3; d++) begin m_v[d] = 1'b0; m_rd[d] = '0; m_ld[d] = 1'b0; end
    m_redir = 1'b0;
    m_cnt   = 0;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0; mem_stall = 1'b0; set_i(nop);

    cycle(); cycle();
    chk("reset f_en", 32'(s_fen), 32'd0);
    chk("reset flush", 32'(s_flush), 32'd1);
    chk("reset bubble", 32'(s_bub), 32'd1);
    chk("reset fwd", 32'({s_fwd1, s_fwd0}), 32'd0);
    chk("reset cnt", 32'(s_cnt), 32'd0);
    rst = 1'b1;

    // Back-to-back ALU producer of x5, readers at distance 1..4.
    set_i(mk(1, 0, 0, 0, 0, 5, 1, 0, 0)); cycle();
    set_i(mk(1, 5, 1, 0, 0, 0, 0, 0, 0)); cycle();
    chk("alu dist1", 32'(s_fwd0), 32'd1);
    chk("alu dist1 nobub", 32'(s_bub), 32'd0);
    cycle(); chk("alu dist2", 32'(s_fwd0), 32'd2);
    cycle(); chk("alu dist3", 32'(s_fwd0), 32'd3);
    cycle(); chk("alu dist4", 32'(s_fwd0), 32'd0);

    // Load x6 then consumer via rs2.
    set_i(mk(1, 0, 0, 0, 0, 6, 1, 1, 0)); cycle();
    set_i(mk(1, 0, 0, 6, 1, 1, 1, 0, 0)); cycle();
    chk("lu f_en", 32'(s_fen), 32'd0);
    chk("lu bubble", 32'(s_bub), 32'd1);
    chk("lu d_en", 32'(s_den), 32'd1);
    cycle();
    chk("lu after fwd", 32'(s_fwd1), 32'd2);
    chk("lu after f_en", 32'(s_fen), 32'd1);
    chk("lu cnt", 32'(s_cnt), 32'd1);

    // JAL taken in decode, flushed slot follows.
    set_i(mk(1, 0, 0, 0, 0, 0, 0, 0, 1)); cycle();
    chk("jal flush", 32'(s_flush), 32'd1);
    set_i(nop); cycle();
    chk("jal slot flush", 32'(s_flush), 32'd0);
    chk("jal slot bubble", 32'(s_bub), 32'd0);

    // Load x7 then taken branch reading x7: bubble first, flush next.
    set_i(mk(1, 0, 0, 0, 0, 7, 1, 1, 0)); cycle();
    set_i(mk(1, 7, 1, 0, 0, 0, 0, 0, 1)); cycle();
    chk("ldbr bubble", 32'(s_bub), 32'd1);
    chk("ldbr no flush", 32'(s_flush), 32'd0);
    cycle();
    chk("ldbr flush", 32'(s_flush), 32'd1);
    chk("ldbr bubble2", 32'(s_bub), 32'd0);
    chk("ldbr fwd", 32'(s_fwd0), 32'd2);
    set_i(nop); cycle();

    // mem_stall for 3 cycles with x9 producer in EX.
    set_i(mk(1, 0, 0, 0, 0, 9, 1, 0, 0)); cycle();
    set_i(mk(1, 9, 1, 0, 0, 0, 0, 0, 0)); mem_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("mstall f_en", 32'(s_fen), 32'd0);
      chk("mstall d_en", 32'(s_den), 32'd0);
      chk("mstall fwd", 32'(s_fwd0), 32'd1);
    end
    mem_stall = 1'b0; cycle();
    chk("mstall cnt", 32'(s_cnt), 32'd5);
    chk("mstall fwd after", 32'(s_fwd0), 32'd1);

    // x0 never forwards.
    set_i(mk(1, 0, 0, 0, 0, 0, 1, 0, 0)); cycle();
    set_i(mk(1, 0, 1, 0, 1, 0, 0, 0, 0)); cycle();
    chk("x0 fwd", 32'({s_fwd1, s_fwd0}), 32'd0);

    // Reset while in STALL.
    set_i(mk(1, 0, 0, 0, 0, 3, 1, 1, 0)); cycle();
    set_i(mk(1, 3, 1, 0, 0, 0, 0, 0, 0)); cycle();
    chk("pre-rst bubble", 32'(s_bub), 32'd1);
    rst = 1'b0; cycle();
    rst = 1'b1; cycle();
    chk("post-rst fwd", 32'({s_fwd1, s_fwd0}), 32'd0);
    chk("post-rst bubble", 32'(s_bub), 32'd0);
    chk("post-rst cnt", 32'(s_cnt), 32'd0);

    // Random traffic; decode holds while fetch->decode is frozen.
    hold = 1'b0;
    cur  = nop;
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(99) != 0);
      mem_stall = ($urandom_range(99) < 15);
      if (!hold) begin
        if (m_redir) begin
          cur = nop;
        end else if ($urandom_range(9) == 0) begin
          cur = nop;
        end else begin
          cur = mk(1, $urandom_range(3), 1'($urandom_range(1)), $urandom_range(3),
                   1'($urandom_range(1)), $urandom_range(3), 1'b0, 1'b0,
                   ($urandom_range(99) < 15));
          cur.we = ($urandom_range(9) < 6);
          cur.ld = cur.we && ($urandom_range(9) < 3);
        end
      end
      set_i(cur);
      cycle();
      hold = rst && !e_fen;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
